// File: rtl/sequenciador_ula_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state codes and default widths.
package sequenciador_ula_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_OP_W    = 3;
  localparam int DEF_TIMEOUT = 15;

  // Codes are visible on the estado LEDs, so they are fixed explicitly.
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_WAIT = 3'd4,
    S_SHOW = 3'd5
  } estado_t;

endpackage

// File: rtl/sequenciador_ula_if.sv
// Sequencer <-> ALU bus: operands/opcode/start out, ready/result back.
interface sequenciador_ula_if
  import sequenciador_ula_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = DEF_OP_W
);
  logic [DATA_W-1:0] ula_a;
  logic [DATA_W-1:0] ula_b;
  logic [OP_W-1:0]   ula_op;
  logic              ula_inicia;
  logic              ula_pronta;
  logic [DATA_W-1:0] ula_resultado;

  modport master (
    output ula_a, ula_b, ula_op, ula_inicia,
    input  ula_pronta, ula_resultado
  );

  modport slave (
    input  ula_a, ula_b, ula_op, ula_inicia,
    output ula_pronta, ula_resultado
  );
endinterface

// File: rtl/sequenciador_ula_detector_borda.sv
// Rising-edge detector for a debounced level: one pulse per press, however long it is held.
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulso
);
  logic in_q;

  always_ff @(posedge clk) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in;
  end

  assign pulso = in & ~in_q;
endmodule

// File: rtl/sequenciador_ula.sv
// Operation sequencer: collects A, B and opcode on Enter presses, launches the ALU,
// waits for ula_pronta with a timeout, and latches the result (Reuso feeds it back as A).
module sequenciador_ula
  import sequenciador_ula_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int TIMEOUT = DEF_TIMEOUT
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               enter,
  input  logic               reuso,
  input  logic [DATA_W-1:0]  sw_dados,
  input  logic [OP_W-1:0]    sw_op,
  sequenciador_ula_if.master ula,
  output logic [DATA_W-1:0]  resultado,
  output logic               res_valido,
  output logic               erro_timeout,
  output logic [2:0]         estado
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  estado_t state_q, state_d;

  logic              ent_p, reu_p;
  logic [TMR_W-1:0]  timer_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [OP_W-1:0]   op_q;
  logic              val_q, err_q;

  logic ld_a_res, ld_a_sw, ld_b, ld_op, ld_tmr, dec_tmr, ld_res, set_err, clr_err;

  detector_borda u_borda_enter (.clk(clk), .rst(rst), .in(enter), .pulso(ent_p));
  detector_borda u_borda_reuso (.clk(clk), .rst(rst), .in(reuso), .pulso(reu_p));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_A;
    else     state_q <= state_d;
  end

  // Next state and datapath load enables; buttons are ignored in S_EXEC/S_WAIT.
  always_comb begin
    state_d  = state_q;
    ld_a_res = 1'b0;
    ld_a_sw  = 1'b0;
    ld_b     = 1'b0;
    ld_op    = 1'b0;
    ld_tmr   = 1'b0;
    dec_tmr  = 1'b0;
    ld_res   = 1'b0;
    set_err  = 1'b0;
    clr_err  = 1'b0;
    case (state_q)
      S_A: begin
        if (reu_p && val_q) begin
          ld_a_res = 1'b1;
          state_d  = S_B;
        end else if (ent_p) begin
          ld_a_sw = 1'b1;
          state_d = S_B;
        end
      end
      S_B: begin
        if (ent_p) begin
          ld_b    = 1'b1;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (ent_p) begin
          ld_op   = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        ld_tmr  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A ready on the expiry cycle still counts as success.
        if (ula.ula_pronta) begin
          ld_res  = 1'b1;
          state_d = S_SHOW;
        end else if (timer_q == TMR_W'(1)) begin
          set_err = 1'b1;
          state_d = S_SHOW;
        end else begin
          dec_tmr = 1'b1;
        end
      end
      S_SHOW: begin
        if (reu_p && val_q) begin
          ld_a_res = 1'b1;
          state_d  = S_B;
        end else if (ent_p) begin
          clr_err = 1'b1;
          state_d = S_A;
        end
      end
      default: state_d = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      timer_q <= '0;
      res_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (ld_a_res)     a_q <= res_q;
      else if (ld_a_sw) a_q <= sw_dados;
      if (ld_b)  b_q  <= sw_dados;
      if (ld_op) op_q <= sw_op;
      if (ld_tmr)       timer_q <= TMR_W'(TIMEOUT);
      else if (dec_tmr) timer_q <= timer_q - TMR_W'(1);
      if (ld_res) begin
        res_q <= ula.ula_resultado;
        val_q <= 1'b1;
        err_q <= 1'b0;
      end else if (set_err) begin
        val_q <= 1'b0;
        err_q <= 1'b1;
      end else if (clr_err) begin
        err_q <= 1'b0;
      end
    end
  end

  assign ula.ula_a      = a_q;
  assign ula.ula_b      = b_q;
  assign ula.ula_op     = op_q;
  assign ula.ula_inicia = (state_q == S_EXEC);
  assign resultado      = res_q;
  assign res_valido     = val_q;
  assign erro_timeout   = err_q;
  assign estado         = state_q;
endmodule

// File: tb/tb_sequenciador_ula.sv
// Bench for sequenciador_ula: directed scenarios plus random stimulus, every cycle compared
// against a phase-level behavioural model.
module tb_sequenciador_ula;
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enter = 1'b0, reuso = 1'b0;
  logic [7:0] sw_dados = '0;
  logic [2:0] sw_op = '0;
  logic [7:0] resultado;
  logic       res_valido, erro_timeout;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  sequenciador_ula_if #(.DATA_W(8), .OP_W(3)) u_if ();

  sequenciador_ula #(.DATA_W(8), .OP_W(3), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enter(enter), .reuso(reuso),
    .sw_dados(sw_dados), .sw_op(sw_op), .ula(u_if),
    .resultado(resultado), .res_valido(res_valido),
    .erro_timeout(erro_timeout), .estado(estado)
  );

  always #5 clk = ~clk;

  // Model: phase 0..5 = collecting A, B, op, launching, waiting, showing.
  typedef struct packed {
    int         phase;
    int         waited;
    logic [7:0] a, b, res;
    logic [2:0] op;
    logic       valid, err, en_prev, ru_prev;
  } mdl_t;

  mdl_t mdl = '0;

  function automatic mdl_t step(mdl_t m, logic r, logic en, logic ru, logic [7:0] d,
                                logic [2:0] o, logic pr, logic [7:0] rr);
    mdl_t n = m;
    logic ep = en && !m.en_prev;
    logic rp = ru && !m.ru_prev;
    n.en_prev = en;
    n.ru_prev = ru;
    if (r) return '0;
    case (m.phase)
      0: if (rp && m.valid) begin n.a = m.res; n.phase = 1; end
         else if (ep) begin n.a = d; n.phase = 1; end
      1: if (ep) begin n.b = d; n.phase = 2; end
      2: if (ep) begin n.op = o; n.phase = 3; end
      3: begin n.phase = 4; n.waited = 0; end
      4: begin
        n.waited = m.waited + 1;
        if (pr) begin n.res = rr; n.valid = 1'b1; n.err = 1'b0; n.phase = 5; end
        else if (n.waited >= TMO) begin n.err = 1'b1; n.valid = 1'b0; n.phase = 5; end
      end
      default: if (rp && m.valid) begin n.a = m.res; n.phase = 1; end
               else if (ep) begin n.err = 1'b0; n.phase = 0; end
    endcase
    return n;
  endfunction

  always @(posedge clk)
    mdl <= step(mdl, rst, enter, reuso, sw_dados, sw_op, u_if.ula_pronta, u_if.ula_resultado);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  // Single per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (chk_on)
      chk("cycle", {estado, u_if.ula_inicia, u_if.ula_a, u_if.ula_b, u_if.ula_op,
                    resultado, res_valido, erro_timeout},
          {mdl.phase[2:0], mdl.phase == 3, mdl.a, mdl.b, mdl.op, mdl.res, mdl.valid, mdl.err});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] d, input logic [2:0] o);
    sw_dados = d;
    sw_op    = o;
    enter    = 1'b1;
    tick(1);
    enter    = 1'b0;
    tick(1);
  endtask

  initial begin
    u_if.ula_pronta    = 1'b0;
    u_if.ula_resultado = '0;
    tick(2);
    chk_on = 1'b1;
    rst = 1'b0;
    chk("reset", {estado, u_if.ula_inicia, u_if.ula_a, u_if.ula_b, u_if.ula_op, resultado,
                  res_valido, erro_timeout}, '0);

    // Basic add: 5 + 3
    press(8'h05, 3'b000);
    chk("add_a", {estado, u_if.ula_a}, {3'd1, 8'h05});
    press(8'h03, 3'b000);
    chk("add_b", {estado, u_if.ula_b}, {3'd2, 8'h03});
    sw_op = 3'b000;
    enter = 1'b1;
    tick(1);
    chk("add_inicia", {estado, u_if.ula_inicia}, {3'd3, 1'b1});
    enter = 1'b0;
    tick(1);
    chk("add_inicia_off", {estado, u_if.ula_inicia}, {3'd4, 1'b0});
    tick(1);
    u_if.ula_pronta = 1'b1; u_if.ula_resultado = 8'h08;
    tick(1);
    u_if.ula_pronta = 1'b0;
    chk("add_res", {estado, resultado, res_valido, erro_timeout}, {3'd5, 8'h08, 2'b10});
    chk("model_pin_add", {mdl.res, mdl.a, mdl.b}, {8'h08, 8'h05, 8'h03});

    // Reuso: 08 becomes A
    reuso = 1'b1; tick(1); reuso = 1'b0; tick(1);
    chk("reuso_a", {estado, u_if.ula_a}, {3'd1, 8'h08});
    press(8'h02, 3'b000);
    press(8'h00, 3'b001);
    u_if.ula_pronta = 1'b1; u_if.ula_resultado = 8'h0A;
    tick(1);
    u_if.ula_pronta = 1'b0;
    chk("reuso_res", {u_if.ula_a, u_if.ula_b, u_if.ula_op, resultado, estado},
        {8'h08, 8'h02, 3'b001, 8'h0A, 3'd5});

    // Timeout: pronta never comes
    press(8'h00, 3'b000);                  // S_SHOW -> S_A
    press(8'h11, 3'b000);
    press(8'h22, 3'b000);
    press(8'h00, 3'b010);                  // now in first S_WAIT cycle
    tick(TMO - 1);
    chk("tmo_still_wait", {estado, erro_timeout}, {3'd4, 1'b0});
    tick(1);
    chk("tmo_err", {estado, erro_timeout, res_valido, resultado}, {3'd5, 1'b1, 1'b0, 8'h0A});
    chk("model_pin_tmo", {mdl.err, mdl.valid}, 2'b10);
    press(8'h00, 3'b000);
    chk("tmo_clear", {estado, erro_timeout}, {3'd0, 1'b0});

    // Boundary: pronta on the last allowed S_WAIT cycle
    press(8'h01, 3'b000);
    press(8'h02, 3'b000);
    press(8'h00, 3'b011);
    tick(TMO - 1);
    u_if.ula_pronta = 1'b1; u_if.ula_resultado = 8'h77;
    tick(1);
    u_if.ula_pronta = 1'b0;
    chk("bound_res", {estado, resultado, res_valido, erro_timeout}, {3'd5, 8'h77, 2'b10});

    // Held Enter gives a single advance
    press(8'h00, 3'b000);
    sw_dados = 8'h5A;
    enter = 1'b1;
    tick(20);
    enter = 1'b0;
    tick(1);
    chk("held_enter", {estado, u_if.ula_a}, {3'd1, 8'h5A});

    // Reuso after reset is ignored
    rst = 1'b1; tick(1); rst = 1'b0;
    reuso = 1'b1; tick(1); reuso = 1'b0; tick(1);
    chk("reuso_ignored", {estado, res_valido}, {3'd0, 1'b0});

    // Reset in S_WAIT
    press(8'h0F, 3'b000);
    press(8'hF0, 3'b000);
    press(8'h00, 3'b100);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_mid", {estado, u_if.ula_inicia, u_if.ula_a, u_if.ula_b, u_if.ula_op, resultado,
                    res_valido, erro_timeout}, '0);
    u_if.ula_pronta = 1'b1; u_if.ula_resultado = 8'hEE;
    tick(2);
    u_if.ula_pronta = 1'b0;
    chk("rst_pronta_ignored", {estado, resultado, res_valido}, '0);

    // Random stimulus, checked every cycle by the compare process
    for (int i = 0; i < 4000; i++) begin
      enter              = ($urandom_range(0, 9) < 4);
      reuso              = ($urandom_range(0, 9) < 2);
      sw_dados           = 8'($urandom);
      sw_op              = 3'($urandom);
      u_if.ula_pronta    = ($urandom_range(0, 9) < 3);
      u_if.ula_resultado = 8'($urandom);
      rst                = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
